// File: rtl/fetch_redirect.sv
// ---------------------------------------------------------------------------
// fetch_redirect
//   Fetch-side control between instruction memory and decode. Owns the PC,
//   issues one imem request at a time (valid/ready), buffers the returned
//   word for decode and redirects the PC when execute resolves a taken
//   branch or jump.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid_o       imem request valid
//   req_ready_i       imem accepts the request this cycle
//   req_addr_o        imem request address (held stable while pending)
//   resp_valid_i      imem response valid (one per accepted request)
//   resp_data_i       imem response word
//   redirect_i        execute: branch/jump taken
//   target_i          execute: redirect target
//   stall_i           decode cannot accept an instruction this cycle
//   insn_valid_o      buffered instruction valid (killed by same-cycle redirect)
//   insn_o, pc_o      buffered instruction and its PC
//   misalign_o        1-cycle pulse: accepted redirect target had [1:0]!=0
//   fetch_count_o     instructions delivered to decode (wrapping)
// ---------------------------------------------------------------------------
module fetch_redirect #(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter logic [31:0]       CNT_INIT = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              resp_valid_i,
    input  logic [DWIDTH-1:0] resp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] target_i,
    input  logic              stall_i,
    output logic              insn_valid_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              misalign_o,
    output logic [31:0]       fetch_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e            state_q;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] pc_d;
    logic [AWIDTH-1:0] req_addr_q;
    logic [AWIDTH-1:0] pc_out_q;
    logic [DWIDTH-1:0] insn_q;
    logic              out_valid_q;
    logic              kill_q;
    logic              misalign_q;
    logic [31:0]       count_q;

    logic              redirect_act;
    logic              resp_accept;
    logic              hold_req;

    // Redirects are only honoured once fetch is running (not in IDLE).
    assign redirect_act = redirect_i && (state_q != IDLE);

    // A response is kept only if neither an older nor a same-cycle redirect killed it.
    assign resp_accept  = (state_q == WAIT) && resp_valid_i && !kill_q && !redirect_i;

    // A pending, not-yet-accepted request must keep its address.
    assign hold_req     = (state_q == REQ) && !req_ready_i;

    // Next PC: redirect wins over sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (redirect_act) begin
            pc_d = {target_i[AWIDTH-1:2], 2'b00};
        end else if (resp_accept) begin
            pc_d = pc_q + AWIDTH'(4);
        end
    end

    // Fetch FSM and all registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= BASEADDR;
            req_addr_q  <= BASEADDR;
            pc_out_q    <= '0;
            insn_q      <= '0;
            out_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            misalign_q  <= 1'b0;
            count_q     <= CNT_INIT;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= redirect_act && (target_i[1:0] != 2'b00);
            if (!hold_req) begin
                req_addr_q <= pc_d;
            end
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    // Request already on the bus goes out at the old address; kill its response.
                    if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                    if (req_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_valid_i) begin
                        kill_q <= 1'b0;
                        if (kill_q || redirect_i) begin
                            state_q <= REQ;
                        end else begin
                            insn_q      <= resp_data_i;
                            pc_out_q    <= pc_q;
                            out_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (redirect_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= REQ;
                    end else if (out_valid_q && !stall_i) begin
                        count_q     <= count_q + 32'd1;
                        out_valid_q <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_valid_o   = (state_q == REQ);
    assign req_addr_o    = req_addr_q;
    // Wrong-path instruction is hidden from decode in the redirect cycle itself.
    assign insn_valid_o  = out_valid_q && !redirect_i;
    assign insn_o        = insn_q;
    assign pc_o          = pc_out_q;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_redirect.sv
module tb_fetch_redirect;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [31:0] WINIT = 32'hFFFF_FFFD;
    localparam int          NVEC  = 35;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_ready_i, resp_valid_i, redirect_i, stall_i;
    logic [31:0] resp_data_i, target_i;

    logic        req_valid_o, insn_valid_o, misalign_o;
    logic [31:0] req_addr_o, insn_o, pc_o, fetch_count_o;

    logic        w_req_valid, w_insn_valid, w_misalign;
    logic [31:0] w_req_addr, w_insn, w_pc, w_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_redirect dut (
        .clk(clk), .reset(reset),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .redirect_i(redirect_i), .target_i(target_i), .stall_i(stall_i),
        .insn_valid_o(insn_valid_o), .insn_o(insn_o), .pc_o(pc_o),
        .misalign_o(misalign_o), .fetch_count_o(fetch_count_o)
    );

    // Second instance with the counter preset near the top to exercise wrap-around.
    fetch_redirect #(.CNT_INIT(WINIT)) u_wrap (
        .clk(clk), .reset(reset),
        .req_valid_o(w_req_valid), .req_ready_i(req_ready_i), .req_addr_o(w_req_addr),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .redirect_i(redirect_i), .target_i(target_i), .stall_i(stall_i),
        .insn_valid_o(w_insn_valid), .insn_o(w_insn), .pc_o(w_pc),
        .misalign_o(w_misalign), .fetch_count_o(w_count)
    );

    typedef struct {
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        redir;
        logic [31:0] tgt;
        logic        stall;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_insn;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic rdr, input logic [31:0] tg, input logic st,
                                input logic erv, input logic [31:0] ea, input logic eiv,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic em, input logic [31:0] ec);
        vec_t v;
        v.ready = rdy; v.rsp_v = rv; v.rsp_d = rd; v.redir = rdr; v.tgt = tg; v.stall = st;
        v.e_rv = erv; v.e_addr = ea; v.e_iv = eiv; v.e_insn = ei; v.e_pc = ep;
        v.e_mis = em; v.e_cnt = ec;
        return v;
    endfunction

    // Apply one vector after the falling edge and compare before the next rising edge.
    task automatic apply(input vec_t v, input int idx);
        logic        ok;
        logic [31:0] e_w;
        @(negedge clk);
        reset        = 1'b0;
        req_ready_i  = v.ready;
        resp_valid_i = v.rsp_v;
        resp_data_i  = v.rsp_d;
        redirect_i   = v.redir;
        target_i     = v.tgt;
        stall_i      = v.stall;
        #1;
        e_w = v.e_cnt + WINIT;
        ok = (req_valid_o === v.e_rv) && (req_addr_o === v.e_addr) &&
             (insn_valid_o === v.e_iv) && (misalign_o === v.e_mis) &&
             (fetch_count_o === v.e_cnt) && (w_count === e_w) &&
             (w_req_valid === v.e_rv) && (w_req_addr === v.e_addr) &&
             (w_insn_valid === v.e_iv) && (w_misalign === v.e_mis);
        if (v.e_iv)
            ok = ok && (insn_o === v.e_insn) && (pc_o === v.e_pc) &&
                 (w_insn === v.e_insn) && (w_pc === v.e_pc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL vec%0d: got rv=%b addr=%h iv=%b insn=%h pc=%h mis=%b cnt=%h wcnt=%h; want rv=%b addr=%h iv=%b insn=%h pc=%h mis=%b cnt=%h wcnt=%h",
                     idx, req_valid_o, req_addr_o, insn_valid_o, insn_o, pc_o, misalign_o,
                     fetch_count_o, w_count, v.e_rv, v.e_addr, v.e_iv, v.e_insn, v.e_pc,
                     v.e_mis, v.e_cnt, e_w);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (!(req_valid_o === 1'b0 && req_addr_o === BASE && insn_valid_o === 1'b0 &&
              insn_o === 32'h0 && pc_o === 32'h0 && misalign_o === 1'b0 &&
              fetch_count_o === 32'h0 && w_count === WINIT && w_req_valid === 1'b0)) begin
            failures++;
            $display("FAIL %s: got rv=%b addr=%h iv=%b insn=%h pc=%h mis=%b cnt=%h wcnt=%h; want 0 %h 0 0 0 0 0 %h",
                     name, req_valid_o, req_addr_o, insn_valid_o, insn_o, pc_o, misalign_o,
                     fetch_count_o, w_count, BASE, WINIT);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic pend, done, seen;

        // cycle-by-cycle: rdy rspv rspd redir tgt stall | rv addr iv insn pc mis cnt
        // Test 1: three back-to-back fetches
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, BASE,       0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0,  1, BASE,       0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 32'h1111_0001, 0, 0, 0,  0, BASE, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0,  0, BASE+4,     1, 32'h1111_0001, BASE,   0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0,  1, BASE+4,     0, 0, 0, 0, 1);
        vecs[5]  = mk(1, 1, 32'h1111_0002, 0, 0, 0,  0, BASE+4, 0, 0, 0, 0, 1);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0,  0, BASE+8,     1, 32'h1111_0002, BASE+4, 0, 1);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0,  1, BASE+8,     0, 0, 0, 0, 2);
        vecs[8]  = mk(1, 1, 32'h1111_0003, 0, 0, 0,  0, BASE+8, 0, 0, 0, 0, 2);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0,  0, BASE+12,    1, 32'h1111_0003, BASE+8, 0, 2);
        vecs[10] = mk(1, 0, 0, 0, 0, 0,  1, BASE+12,    0, 0, 0, 0, 3);
        // Test 2: decode stalls for 5 cycles
        vecs[11] = mk(1, 1, 32'h0050_0093, 0, 0, 0,  0, BASE+12, 0, 0, 0, 0, 3);
        for (int i = 12; i <= 16; i++)
            vecs[i] = mk(1, 0, 0, 0, 0, 1,  0, BASE+16, 1, 32'h0050_0093, BASE+12, 0, 3);
        vecs[17] = mk(1, 0, 0, 0, 0, 0,  0, BASE+16,    1, 32'h0050_0093, BASE+12, 0, 3);
        vecs[18] = mk(1, 0, 0, 0, 0, 0,  1, BASE+16,    0, 0, 0, 0, 4);
        // Test 3: redirect while waiting, stale response arrives 2 cycles later
        vecs[19] = mk(1, 0, 0, 1, BASE+32'h40, 0,  0, BASE+16, 0, 0, 0, 0, 4);
        vecs[20] = mk(1, 0, 0, 0, 0, 0,  0, BASE+32'h40, 0, 0, 0, 0, 4);
        vecs[21] = mk(1, 1, 32'hDEAD_BEEF, 0, 0, 0,  0, BASE+32'h40, 0, 0, 0, 0, 4);
        vecs[22] = mk(1, 0, 0, 0, 0, 0,  1, BASE+32'h40, 0, 0, 0, 0, 4);
        vecs[23] = mk(1, 1, 32'h2222_0001, 0, 0, 0,  0, BASE+32'h40, 0, 0, 0, 0, 4);
        // Test 4: redirect while the instruction is presented
        vecs[24] = mk(1, 0, 0, 1, BASE+32'h80, 0,  0, BASE+32'h44, 0, 0, 0, 0, 4);
        vecs[25] = mk(1, 0, 0, 0, 0, 0,  1, BASE+32'h80, 0, 0, 0, 0, 4);
        vecs[26] = mk(1, 1, 32'h2222_0002, 0, 0, 0,  0, BASE+32'h80, 0, 0, 0, 0, 4);
        vecs[27] = mk(1, 0, 0, 0, 0, 0,  0, BASE+32'h84, 1, 32'h2222_0002, BASE+32'h80, 0, 4);
        // Test 5: misaligned redirect while a request is pending and not yet accepted
        vecs[28] = mk(0, 0, 0, 1, BASE+32'h43, 0,  1, BASE+32'h84, 0, 0, 0, 0, 5);
        vecs[29] = mk(1, 0, 0, 0, 0, 0,  1, BASE+32'h84, 0, 0, 0, 1, 5);
        vecs[30] = mk(1, 1, 32'hBAD0_0043, 0, 0, 0,  0, BASE+32'h40, 0, 0, 0, 0, 5);
        vecs[31] = mk(1, 0, 0, 0, 0, 0,  1, BASE+32'h40, 0, 0, 0, 0, 5);
        vecs[32] = mk(1, 1, 32'h2222_0003, 0, 0, 0,  0, BASE+32'h40, 0, 0, 0, 0, 5);
        vecs[33] = mk(1, 0, 0, 0, 0, 0,  0, BASE+32'h44, 1, 32'h2222_0003, BASE+32'h40, 0, 5);
        vecs[34] = mk(1, 0, 0, 0, 0, 0,  1, BASE+32'h44, 0, 0, 0, 0, 6);

        reset = 1'b1; req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;
        redirect_i = 1'b0; target_i = '0; stall_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset("reset_state");
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

        // Test 6: reset while waiting; imem answers after reset and must be ignored.
        @(negedge clk);
        reset = 1'b1; resp_valid_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0; req_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; resp_valid_i = 1'b1; resp_data_i = 32'hBAD0_0006;
        #1;
        check_reset("reset_mid_wait");
        pend = 1'b0; done = 1'b0; seen = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            resp_valid_i = pend;
            resp_data_i  = 32'h3333_0001;
            pend = 1'b0;
            #1;
            if (insn_valid_o) begin
                check32("post_reset_insn", insn_o, 32'h3333_0001);
                check32("post_reset_pc", pc_o, BASE);
                done = 1'b1;
            end
            if (req_valid_o) begin
                if (!seen) check32("post_reset_req_addr", req_addr_o, BASE);
                seen = 1'b1;
                pend = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL post_reset_timeout: got no insn_valid_o within 20 cycles, want one");
        end
        @(negedge clk);
        resp_valid_i = 1'b0;
        #1;
        check32("post_reset_count", fetch_count_o, 32'd1);
        check32("post_reset_wrap_count", w_count, 32'hFFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
